// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared constants and types for the VGA display timing generator.
//   - 640x480@60 default active, porch and sync widths plus derived totals
//   - sync polarity constants
//   - coord_t: default-width coordinate type for row/column values
//   - max_int: helper used for the counter-width elaboration check
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Horizontal defaults, in pixels
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;

  // Vertical defaults, in lines
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // Sync active levels
  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

  // Default coordinate width and type
  localparam int DEF_CNT_W = 11;
  typedef logic [DEF_CNT_W-1:0] coord_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_timing_gen_if.sv
// -----------------------------------------------------------------------------
// display_timing_gen_if
// Bundle between the timing generator and its downstream consumers
// (colorizer / pixel-source logic).
//   pix_en        pixel-advance strobe (consumer side drives it)
//   horiz_sync    horizontal sync
//   vert_sync     vertical sync
//   video_on      visible-area flag
//   pixel_column  current horizontal count
//   pixel_row     current vertical count
//   line_start    one-clock pulse on entry to column 0
//   frame_start   one-clock pulse on entry to (0,0)
// Modports: master = timing generator, slave = consumer.
// -----------------------------------------------------------------------------
interface display_timing_gen_if #(
  parameter int CNT_W = 11
) ();

  logic             pix_en;
  logic             horiz_sync;
  logic             vert_sync;
  logic             video_on;
  logic [CNT_W-1:0] pixel_column;
  logic [CNT_W-1:0] pixel_row;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  pix_en,
    output horiz_sync, vert_sync, video_on,
    output pixel_column, pixel_row,
    output line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  horiz_sync, vert_sync, video_on,
    input  pixel_column, pixel_row,
    input  line_start, frame_start
  );

endinterface

// File: rtl/display_timing_gen_wrap_counter.sv
// -----------------------------------------------------------------------------
// wrap_counter
// Modulo-N counter with enable. Resets to N-1 so the first enabled step
// lands on 0.
//   clock      rising-edge clock
//   reset      asynchronous active-high reset
//   en_i       step enable
//   count_o    currently held count
//   count_d_o  count that will be held after this clock edge
//   tc_o       terminal count (count_o == N-1)
// -----------------------------------------------------------------------------
module wrap_counter #(
  parameter int N = 800,
  parameter int W = 11
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] count_d_o,
  output logic         tc_o
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign tc_o = (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (en_i) begin
      count_d = tc_o ? '0 : (count_q + W'(1));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= LAST;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign count_d_o = count_d;

endmodule

// File: rtl/display_timing_gen.sv
// -----------------------------------------------------------------------------
// display_timing_gen
// VGA display timing generator. Steps one pixel per pix_en strobe and
// produces syncs, video_on, the current row/column, and line/frame start
// pulses. Every output is registered from the next-count value so it always
// describes the position currently held in the counters.
//   clock  rising-edge system clock
//   reset  asynchronous active-high reset
//   bus    display_timing_gen_if.master (pix_en in, timing outputs out)
// -----------------------------------------------------------------------------
module display_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit HSYNC_POL = SYNC_ACTIVE_LOW,
  parameter bit VSYNC_POL = SYNC_ACTIVE_LOW,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  display_timing_gen_if.master  bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_BEG = CNT_W'(H_ACTIVE + H_FRONT);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] V_SYNC_BEG = CNT_W'(V_ACTIVE + V_FRONT);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_ACTIVE + V_FRONT + V_SYNC);

  // The counters must be able to hold the largest total minus one.
  if (CNT_W < $clog2(max_int(H_TOTAL, V_TOTAL))) begin : g_cnt_w_check
    $error("display_timing_gen: CNT_W too small for H_TOTAL/V_TOTAL");
  end

  logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
  logic             h_tc, v_tc;
  logic             v_en;

  // Vertical steps only on the pixel that wraps the line.
  assign v_en = bus.pix_en & h_tc;

  wrap_counter #(.N(H_TOTAL), .W(CNT_W)) u_h_cnt (
    .clock     (clock),
    .reset     (reset),
    .en_i      (bus.pix_en),
    .count_o   (h_q),
    .count_d_o (h_d),
    .tc_o      (h_tc)
  );

  wrap_counter #(.N(V_TOTAL), .W(CNT_W)) u_v_cnt (
    .clock     (clock),
    .reset     (reset),
    .en_i      (v_en),
    .count_o   (v_q),
    .count_d_o (v_d),
    .tc_o      (v_tc)
  );

  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic video_q, video_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  always_comb begin
    hsync_d       = ((h_d >= H_SYNC_BEG) && (h_d < H_SYNC_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d       = ((v_d >= V_SYNC_BEG) && (v_d < V_SYNC_END)) ? VSYNC_POL : ~VSYNC_POL;
    video_d       = (h_d < H_VIS_END) && (v_d < V_VIS_END);
    // Entering column 0 happens exactly when an enabled step leaves the
    // terminal column; (0,0) additionally needs the last row.
    line_start_d  = bus.pix_en & h_tc;
    frame_start_d = bus.pix_en & h_tc & v_tc;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      video_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_q       <= video_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.horiz_sync   = hsync_q;
  assign bus.vert_sync    = vsync_q;
  assign bus.video_on     = video_q;
  assign bus.pixel_column = h_q;
  assign bus.pixel_row    = v_q;
  assign bus.line_start   = line_start_q;
  assign bus.frame_start  = frame_start_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_display_timing_gen
// Drives three generators from one clock/reset/pix_en: the default 640x480
// timing, and a small geometry in both sync polarities so whole frames and
// mid-frame resets fit in a short run. Expected values come from a reference
// model that derives position from the number of accepted pixel strobes.
// -----------------------------------------------------------------------------
module tb_display_timing_gen;

  logic clk = 1'b0;
  logic reset;
  logic pix_en;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference-model state: accepted pixel strobes since reset, and whether
  // the most recent edge accepted one.
  longint n_pix = 0;
  bit     last_en = 1'b0;

  display_timing_gen_if #(.CNT_W(11)) if_def ();
  display_timing_gen_if #(.CNT_W(11)) if_lo  ();
  display_timing_gen_if #(.CNT_W(11)) if_hi  ();

  assign if_def.pix_en = pix_en;
  assign if_lo.pix_en  = pix_en;
  assign if_hi.pix_en  = pix_en;

  display_timing_gen dut_def (
    .clock (clk),
    .reset (reset),
    .bus   (if_def)
  );

  display_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_ACTIVE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(11)
  ) dut_lo (
    .clock (clk),
    .reset (reset),
    .bus   (if_lo)
  );

  display_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(4),
    .V_ACTIVE(10), .V_FRONT(1), .V_SYNC(2), .V_BACK(3),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(11)
  ) dut_hi (
    .clock (clk),
    .reset (reset),
    .bus   (if_hi)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Position after n strobes: strobe 1 is pixel (0,0), so the reset position
  // is the last pixel of the frame.
  task automatic check_dut(
    input string nm,
    input int ha, input int hf, input int hsw, input int hb,
    input int va, input int vf, input int vsw, input int vb,
    input bit hpol, input bit vpol,
    input logic hs, input logic vs, input logic vid,
    input logic ls, input logic fs,
    input logic [10:0] col, input logic [10:0] row
  );
    int     ht, vt, ecol, erow;
    longint ft, idx;
    bit     e_hs, e_vs, e_vid, e_ls, e_fs;
    ht   = ha + hf + hsw + hb;
    vt   = va + vf + vsw + vb;
    ft   = longint'(ht) * vt;
    idx  = (n_pix + ft - 1) % ft;
    ecol = int'(idx % ht);
    erow = int'(idx / ht);
    e_vid = (ecol < ha) && (erow < va);
    e_hs  = (ecol >= ha + hf && ecol < ha + hf + hsw) ? hpol : ~hpol;
    e_vs  = (erow >= va + vf && erow < va + vf + vsw) ? vpol : ~vpol;
    e_ls  = last_en && (ecol == 0);
    e_fs  = e_ls && (erow == 0);
    check({nm, ".col"},   32'(col), 32'(ecol));
    check({nm, ".row"},   32'(row), 32'(erow));
    check({nm, ".video"}, 32'(vid), 32'(e_vid));
    check({nm, ".hsync"}, 32'(hs),  32'(e_hs));
    check({nm, ".vsync"}, 32'(vs),  32'(e_vs));
    check({nm, ".lstart"}, 32'(ls), 32'(e_ls));
    check({nm, ".fstart"}, 32'(fs), 32'(e_fs));
  endtask

  task automatic check_all();
    check_dut("def", 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0,
              if_def.horiz_sync, if_def.vert_sync, if_def.video_on,
              if_def.line_start, if_def.frame_start,
              if_def.pixel_column, if_def.pixel_row);
    check_dut("lo", 16, 2, 3, 4, 10, 1, 2, 3, 1'b0, 1'b0,
              if_lo.horiz_sync, if_lo.vert_sync, if_lo.video_on,
              if_lo.line_start, if_lo.frame_start,
              if_lo.pixel_column, if_lo.pixel_row);
    check_dut("hi", 16, 2, 3, 4, 10, 1, 2, 3, 1'b1, 1'b1,
              if_hi.horiz_sync, if_hi.vert_sync, if_hi.video_on,
              if_hi.line_start, if_hi.frame_start,
              if_hi.pixel_column, if_hi.pixel_row);
  endtask

  // One clock: drive pix_en, let the edge happen, update the model, compare.
  task automatic step(input bit en);
    pix_en = en;
    @(posedge clk);
    if (en && !reset) n_pix++;
    last_en = en && !reset;
    #1;
    check_all();
  endtask

  // Reset asserted between edges must take effect with no clock edge.
  task automatic async_reset_pulse();
    #1;
    reset = 1'b1;
    #1;
    n_pix   = 0;
    last_en = 1'b0;
    check_all();
    #2;
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    pix_en = 1'b0;
    // Reset held, with and without pix_en: state stays at reset values.
    for (int i = 0; i < 4; i++) step(i[0]);
    #3;
    reset = 1'b0;

    // Continuous pixel rate: several small frames, a few default lines.
    for (int i = 0; i < 2000; i++) step(1'b1);

    // 1-of-4 strobe: start pulses must last one clock.
    for (int i = 0; i < 4000; i++) step(i % 4 == 0);

    // Random enable pattern.
    for (int i = 0; i < 3000; i++) step($urandom_range(0, 1) == 1);

    // Mid-frame reset at a random point, then restart from (0,0).
    for (int i = 0; i < int'($urandom_range(50, 350)); i++) step(1'b1);
    async_reset_pulse();
    for (int i = 0; i < 1000; i++) step(1'b1);

    // Second mid-frame reset after random activity, with idle clocks after.
    for (int i = 0; i < int'($urandom_range(20, 300)); i++) step($urandom_range(0, 3) != 0);
    async_reset_pulse();
    for (int i = 0; i < 3; i++) step(1'b0);
    for (int i = 0; i < 500; i++) step(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
